// File: rtl/ram_arb2_if.sv
// Two-port requester bus plus the registered RAM control side
// of the ram_arb2 arbiter.
interface ram_arb2_if #(
    parameter int AWID = 8,
    parameter int DWID = 16
);
    logic            p0_req;
    logic            p0_we;
    logic            p0_lock;
    logic [AWID-1:0] p0_addr;
    logic [DWID-1:0] p0_wdata;
    logic            p0_gnt;
    logic            p0_rvalid;
    logic [DWID-1:0] p0_rdata;

    logic            p1_req;
    logic            p1_we;
    logic            p1_lock;
    logic [AWID-1:0] p1_addr;
    logic [DWID-1:0] p1_wdata;
    logic            p1_gnt;
    logic            p1_rvalid;
    logic [DWID-1:0] p1_rdata;

    logic            ram_we;
    logic [AWID-1:0] ram_addr;
    logic [DWID-1:0] ram_din;
    logic [DWID-1:0] ram_dout;

    modport slave (
        input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
        input  ram_dout,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output ram_we, ram_addr, ram_din
    );

    modport master (
        output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
        output ram_dout,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_arb2.sv
// Two-port round-robin RAM arbiter with bounded lock ownership
// and a 2-stage read-valid return pipeline.
module ram_arb2 #(
    parameter int DEPTH    = 256,
    parameter int AWID     = 8,
    parameter int DWID     = 16,
    parameter int MAX_LOCK = 16
) (
    input logic     clk,
    input logic     rst_n,
    ram_arb2_if.slave bus
);
    if (DEPTH > (1 << AWID)) begin : g_depth_chk
        $error("DEPTH exceeds address space");
    end

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     state;
    state_t     state_nx;
    logic       last;
    logic [7:0] lock_cnt;
    logic       forced;
    logic       g0;
    logic       g1;
    logic [1:0] rv_v;
    logic [1:0] rv_p;

    always_comb begin
        state_nx = state;
        g0       = 1'b0;
        g1       = 1'b0;
        forced   = lock_cnt >= 8'(MAX_LOCK);
        unique case (state)
            IDLE: begin
                if (bus.p0_req && bus.p1_req) begin
                    g0 = last;
                    g1 = !last;
                end else begin
                    g0 = bus.p0_req;
                    g1 = bus.p1_req;
                end
                if (g0 && bus.p0_lock)
                    state_nx = OWN0;
                else if (g1 && bus.p1_lock)
                    state_nx = OWN1;
            end
            OWN0: begin
                if (forced) begin
                    // the waiting port wins the release cycle
                    g1       = bus.p1_req;
                    g0       = bus.p0_req && !bus.p1_req;
                    state_nx = IDLE;
                end else begin
                    g0 = bus.p0_req;
                    if (!bus.p0_lock)
                        state_nx = IDLE;
                end
            end
            OWN1: begin
                if (forced) begin
                    g0       = bus.p0_req;
                    g1       = bus.p1_req && !bus.p0_req;
                    state_nx = IDLE;
                end else begin
                    g1 = bus.p1_req;
                    if (!bus.p1_lock)
                        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.p0_gnt = g0 && rst_n;
    assign bus.p1_gnt = g1 && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            lock_cnt <= '0;
        end else begin
            state <= state_nx;
            if (g0)
                last <= 1'b0;
            else if (g1)
                last <= 1'b1;
            if (state == IDLE)
                lock_cnt <= '0;
            else
                lock_cnt <= lock_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ram_we   <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_din  <= '0;
            rv_v         <= '0;
            rv_p         <= '0;
        end else begin
            if (g0) begin
                bus.ram_we   <= bus.p0_we;
                bus.ram_addr <= bus.p0_addr;
                bus.ram_din  <= bus.p0_wdata;
            end else if (g1) begin
                bus.ram_we   <= bus.p1_we;
                bus.ram_addr <= bus.p1_addr;
                bus.ram_din  <= bus.p1_wdata;
            end else begin
                bus.ram_we <= 1'b0;
            end
            rv_v[0] <= (g0 && !bus.p0_we) || (g1 && !bus.p1_we);
            rv_p[0] <= g1;
            rv_v[1] <= rv_v[0];
            rv_p[1] <= rv_p[0];
        end
    end

    assign bus.p0_rvalid = rv_v[1] && !rv_p[1];
    assign bus.p1_rvalid = rv_v[1] && rv_p[1];
    assign bus.p0_rdata  = bus.ram_dout;
    assign bus.p1_rdata  = bus.ram_dout;
endmodule
